// File: rtl/multicycle_main_controller.sv
// Moore control FSM for the multicycle MIPS datapath.
// Sequences each instruction over 3-5 states on a shared ALU and a single memory port.
// Memory states wait on MemReady. A bounded wait counter traps a stalled bus in ERROR.
module multicycle_main_controller #(
  parameter int OPCODE_W    = 6,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                Branch,
  output logic [1:0]          PCSrc,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic                IllegalOp,
  output logic                BusErr,
  output logic [3:0]          State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_ERROR  = 4'd12
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);

  // A timeout of 0 disables the counter entirely; keep it at least one bit wide.
  localparam bit          TO_EN     = (MEM_TIMEOUT > 0);
  localparam int          CW        = TO_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int          TO_LAST_I = TO_EN ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          bus_err_q;
  logic          wait_st;

  // State, wait counter and sticky bus-error flag.
  // Because the outputs decode state, an async reset drops writes at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_FETCH;
      cnt       <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bus_err_q <= bus_err_q | (state_n == S_ERROR);
    end
  end

  // Next-state and Moore outputs. IRWrite/PCWrite in FETCH follow MemReady.
  // The only other input-dependent output is IllegalOp in DECODE.
  always_comb begin
    state_n   = state;
    wait_st   = 1'b0;
    PCWrite   = 1'b0;
    Branch    = 1'b0;
    PCSrc     = 2'b00;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    IllegalOp = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        wait_st = 1'b1;
        if (MemReady) state_n = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_R:         state_n = S_EXEC;
          OP_BEQ:       state_n = S_BRANCH;
          OP_ADDI:      state_n = S_ADDIEX;
          OP_J:         state_n = S_JUMP;
          default: begin
            IllegalOp = 1'b1;
            state_n   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (Opcode == OP_LW)      state_n = S_MEMRD;
        else if (Opcode == OP_SW) state_n = S_MEMWR;
        else                      state_n = S_FETCH;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        wait_st = 1'b1;
        if (MemReady) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_n  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        wait_st  = 1'b1;
        if (MemReady) state_n = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_n = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_n  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
        state_n = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_n = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        state_n  = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        state_n = S_FETCH;
      end
      S_ERROR: state_n = S_ERROR;
      default: state_n = S_FETCH;
    endcase
    // A completing access in the last allowed cycle still wins over the timeout.
    if (TO_EN && wait_st && !MemReady && cnt == TO_LAST) state_n = S_ERROR;
  end

  // The wait counter restarts on every state change.
  // That covers entry into FETCH, MEMRD and MEMWR.
  always_comb begin
    cnt_n = cnt;
    if (state_n != state)                     cnt_n = '0;
    else if (TO_EN && wait_st && !MemReady)   cnt_n = cnt + 1'b1;
  end

  assign BusErr = bus_err_q;
  assign State  = state;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Directed bench for the multicycle main controller (MEM_TIMEOUT=4).
// Inputs are driven on the falling edge, and outputs are checked 1ns later.
module tb_multicycle_main_controller;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] Opcode;
  logic       MemReady;
  logic       PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA, IllegalOp, BusErr;
  logic [1:0] PCSrc, ALUSrcB, ALUOp;
  logic [3:0] State;
  logic [17:0] ctl;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  multicycle_main_controller #(.OPCODE_W(6), .MEM_TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .IllegalOp(IllegalOp), .BusErr(BusErr), .State(State)
  );

  // {PCWrite,Branch,PCSrc,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,IllegalOp,BusErr}
  assign ctl = {PCWrite, Branch, PCSrc, IorD, MemRead, MemWrite, IRWrite,
                RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, IllegalOp, BusErr};

  localparam logic [17:0] C_F1  = 18'b1_0_00_0_1_0_1_0_0_0_0_01_00_0_0;
  localparam logic [17:0] C_F0  = 18'b0_0_00_0_1_0_0_0_0_0_0_01_00_0_0;
  localparam logic [17:0] C_DEC = 18'b0_0_00_0_0_0_0_0_0_0_0_11_00_0_0;
  localparam logic [17:0] C_ILL = 18'b0_0_00_0_0_0_0_0_0_0_0_11_00_1_0;
  localparam logic [17:0] C_MAD = 18'b0_0_00_0_0_0_0_0_0_0_1_10_00_0_0;
  localparam logic [17:0] C_MRD = 18'b0_0_00_1_1_0_0_0_0_0_0_00_00_0_0;
  localparam logic [17:0] C_MWB = 18'b0_0_00_0_0_0_0_0_1_1_0_00_00_0_0;
  localparam logic [17:0] C_MWR = 18'b0_0_00_1_0_1_0_0_0_0_0_00_00_0_0;
  localparam logic [17:0] C_EXE = 18'b0_0_00_0_0_0_0_0_0_0_1_00_10_0_0;
  localparam logic [17:0] C_AWB = 18'b0_0_00_0_0_0_0_1_0_1_0_00_00_0_0;
  localparam logic [17:0] C_BRA = 18'b0_1_01_0_0_0_0_0_0_0_1_00_01_0_0;
  localparam logic [17:0] C_IWB = 18'b0_0_00_0_0_0_0_0_0_1_0_00_00_0_0;
  localparam logic [17:0] C_JMP = 18'b1_0_10_0_0_0_0_0_0_0_0_00_00_0_0;
  localparam logic [17:0] C_ERR = 18'b0_0_00_0_0_0_0_0_0_0_0_00_00_0_1;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

  task automatic test_reset();
    RST = 1'b1; MemReady = 1'b0; Opcode = 6'd0;
    #1;
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL reset state: got %0d want 0", State); end
    checks++; if (ctl !== C_F0) begin errors++; $display("FAIL reset ctl mr=0: got %b want %b", ctl, C_F0); end
    @(negedge CLK);
    MemReady = 1'b1;
    #1;
    checks++; if (ctl !== C_F1) begin errors++; $display("FAIL reset ctl mr=1: got %b want %b", ctl, C_F1); end
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL reset held state: got %0d want 0", State); end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_lw();
    logic [3:0]  st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    logic [17:0] cx [5] = '{C_F1, C_DEC, C_MAD, C_MRD, C_MWB};
    for (int i = 0; i < 5; i++) begin
      Opcode = LW; MemReady = 1'b1;
      #1;
      checks++; if (State !== st[i]) begin errors++; $display("FAIL lw step %0d state: got %0d want %0d", i, State, st[i]); end
      checks++; if (ctl !== cx[i]) begin errors++; $display("FAIL lw step %0d ctl: got %b want %b", i, ctl, cx[i]); end
      @(negedge CLK);
    end
  endtask

  task automatic test_sw_wait();
    logic [3:0]  st [7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
    logic [17:0] cx [7] = '{C_F1, C_DEC, C_MAD, C_MWR, C_MWR, C_MWR, C_MWR};
    logic        mr [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      Opcode = SW; MemReady = mr[i];
      #1;
      checks++; if (State !== st[i]) begin errors++; $display("FAIL sw step %0d state: got %0d want %0d", i, State, st[i]); end
      checks++; if (ctl !== cx[i]) begin errors++; $display("FAIL sw step %0d ctl: got %b want %b", i, ctl, cx[i]); end
      @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  op [14] = '{RT, RT, RT, RT, BEQ, BEQ, BEQ, ADDI, ADDI, ADDI, ADDI, JMP, JMP, JMP};
    logic [3:0]  st [14] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd8,
                             4'd0, 4'd1, 4'd9, 4'd10, 4'd0, 4'd1, 4'd11};
    logic [17:0] cx [14] = '{C_F1, C_DEC, C_EXE, C_AWB, C_F1, C_DEC, C_BRA,
                             C_F1, C_DEC, C_MAD, C_IWB, C_F1, C_DEC, C_JMP};
    for (int i = 0; i < 14; i++) begin
      Opcode = op[i]; MemReady = 1'b1;
      #1;
      checks++; if (State !== st[i]) begin errors++; $display("FAIL b2b step %0d state: got %0d want %0d", i, State, st[i]); end
      checks++; if (ctl !== cx[i]) begin errors++; $display("FAIL b2b step %0d ctl: got %b want %b", i, ctl, cx[i]); end
      @(negedge CLK);
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  st [2] = '{4'd0, 4'd1};
    logic [17:0] cx [2] = '{C_F1, C_ILL};
    for (int i = 0; i < 2; i++) begin
      Opcode = BAD; MemReady = 1'b1;
      #1;
      checks++; if (State !== st[i]) begin errors++; $display("FAIL illegal step %0d state: got %0d want %0d", i, State, st[i]); end
      checks++; if (ctl !== cx[i]) begin errors++; $display("FAIL illegal step %0d ctl: got %b want %b", i, ctl, cx[i]); end
      @(negedge CLK);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 4; i++) begin
      Opcode = LW; MemReady = 1'b0;
      #1;
      checks++; if (State !== 4'd0) begin errors++; $display("FAIL timeout wait %0d state: got %0d want 0", i, State); end
      checks++; if (ctl !== C_F0) begin errors++; $display("FAIL timeout wait %0d ctl: got %b want %b", i, ctl, C_F0); end
      @(negedge CLK);
    end
    for (int i = 0; i < 3; i++) begin
      MemReady = (i != 0); Opcode = SW;
      #1;
      checks++; if (State !== 4'd12) begin errors++; $display("FAIL error hold %0d state: got %0d want 12", i, State); end
      checks++; if (ctl !== C_ERR) begin errors++; $display("FAIL error hold %0d ctl: got %b want %b", i, ctl, C_ERR); end
      @(negedge CLK);
    end
    RST = 1'b1; MemReady = 1'b0;
    #1;
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL error reset state: got %0d want 0", State); end
    checks++; if (ctl !== C_F0) begin errors++; $display("FAIL error reset ctl: got %b want %b", ctl, C_F0); end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_timeout_race();
    logic [5:0]  op [14] = '{SW, SW, SW, SW, SW, SW, SW, SW, SW, SW, LW, LW, LW, LW};
    logic        mr [14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                             1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0]  st [14] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd5,
                             4'd5, 4'd5, 4'd5, 4'd0, 4'd1, 4'd2, 4'd3};
    logic [17:0] cx [14] = '{C_F0, C_F0, C_F0, C_F1, C_DEC, C_MAD, C_MWR,
                             C_MWR, C_MWR, C_MWR, C_F1, C_DEC, C_MAD, C_MRD};
    for (int i = 0; i < 14; i++) begin
      Opcode = op[i]; MemReady = mr[i];
      #1;
      checks++; if (State !== st[i]) begin errors++; $display("FAIL race step %0d state: got %0d want %0d", i, State, st[i]); end
      checks++; if (ctl !== cx[i]) begin errors++; $display("FAIL race step %0d ctl: got %b want %b", i, ctl, cx[i]); end
      if (i != 13) @(negedge CLK);
    end
    // Abort the load mid-MEMRD, away from any clock edge.
    #1 RST = 1'b1;
    #1;
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL async reset state: got %0d want 0", State); end
    checks++; if (ctl !== C_F0) begin errors++; $display("FAIL async reset ctl: got %b want %b", ctl, C_F0); end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_timeout_race();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
